// File: rtl/tpu_pkg.sv
// tpu_pkg: shared operand type and feeder state encoding for the systolic array
package tpu_pkg;
    localparam int DW = 32;
    typedef logic [DW-1:0] data_t;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_e;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with sync reset; DEPTH=0 is a plain wire
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = clk ^ rst;
        assign q = d;
    end else begin : g_sr
        logic [DW-1:0] sr [DEPTH];
        always_ff @(posedge clk) begin
            sr[0] <= rst ? '0 : d;
            for (int k = 1; k < DEPTH; k++) sr[k] <= rst ? '0 : sr[k-1];
        end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B operand slices into an aligned wavefront for the systolic array.
// Optional FEEDER_PERF_EN adds the stall_cycles counter port.
module systolic_feeder #(
    parameter int M = 256,
    parameter int N = 256,
    parameter int DW = 32,
    parameter int K_MAX = 256,
    localparam int BW = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [DW-1:0] in_a [N],
    input  logic [DW-1:0] in_b [M],
    output logic [DW-1:0] feed_a [N],
    output logic [DW-1:0] feed_b [M],
    output logic          busy,
    output logic          tile_done,
    output logic [BW-1:0] tile_beats,
    output logic          err_overflow
`ifdef FEEDER_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);
    import tpu_pkg::*;
    localparam int CW = $clog2(N + M);
    feeder_state_e state, next;
    logic [CW-1:0] drain_cnt;
    logic [BW-1:0] beats, beats_nx;
    logic accept, close;
    logic [DW-1:0] stage_a [N];
    logic [DW-1:0] stage_b [M];
    assign in_ready = state == IDLE || state == STREAM;
    assign accept = in_valid && in_ready;
    assign beats_nx = state == IDLE ? BW'(1) : beats + BW'(1);
    assign close = accept && (in_last || beats_nx == BW'(K_MAX));
    assign busy = state != IDLE;
    assign tile_done = state == DONE;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = close ? DRAIN : accept ? STREAM : IDLE;
            STREAM:  next = close ? DRAIN : STREAM;
            DRAIN:   next = drain_cnt == CW'(N + M - 1) ? DONE : DRAIN;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            drain_cnt <= '0;
            beats <= '0;
            tile_beats <= '0;
            err_overflow <= 1'b0;
        end else begin
            state <= next;
            drain_cnt <= state == DRAIN ? drain_cnt + CW'(1) : '0;
            if (accept) beats <= beats_nx;
            if (close) tile_beats <= beats_nx;
            if (accept) err_overflow <= close && !in_last;
        end
    end
    // Zeros enter every lane together on bubbles and drain, keeping lanes aligned
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) stage_a[i] <= rst || !accept ? '0 : in_a[i];
        for (int j = 0; j < M; j++) stage_b[j] <= rst || !accept ? '0 : in_b[j];
    end
    for (genvar i = 0; i < N; i++) begin : g_a
        skew_delay_line #(.DEPTH(i), .DW(DW)) u_dl (.clk, .rst, .d(stage_a[i]), .q(feed_a[i]));
    end
    for (genvar j = 0; j < M; j++) begin : g_b
        skew_delay_line #(.DEPTH(j), .DW(DW)) u_dl (.clk, .rst, .d(stage_b[j]), .q(feed_b[j]));
    end
`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && accept)) stall_cycles <= '0;
        else if (state == STREAM && !in_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule
